cla_adder_pipe: RTL and testbench

CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

---
 rtl/cla_adder_pipe.sv | 187 ++++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.
// Optional ovf/zero/neg result flags are built when CLA_FLAGS_EN is defined.
module cla_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_bad_group
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP");
  end
  if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be 8, 16, 32 or 64");
  end

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // valid never waits on ready, and an offered result holds until consumed.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, bx_q, bx_d;
  logic             c0_q, c0_d;
  logic [NG-1:0]    gp_q, gp_d, gg_q, gg_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef CLA_FLAGS_EN
  logic             ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
`endif

  logic             s2_load, s2_take, in_accept;
  logic [WIDTH-1:0] bx_in, p_in, g_in, p_s2, g_s2, sum_n;
  logic [NG-1:0]    gp_in, gg_in;
  logic [NG:0]      gc;

  always_comb begin
    s2_load   = !out_valid_q | out_ready;
    s2_take   = s2_load & s1_valid_q;
    in_ready  = !s1_valid_q | s2_load;
    in_accept = in_valid & in_ready;
    bx_in     = sub ? ~b : b;
    p_in      = a ^ bx_in;
    g_in      = a & bx_in;
    gp_in     = '0;
    gg_in     = '0;
    for (int k = 0; k < NG; k++) begin
      gp_in[k] = &p_in[k*GROUP +: GROUP];
      for (int j = 0; j < GROUP; j++) begin
        gg_in[k] = g_in[k*GROUP+j] | (p_in[k*GROUP+j] & gg_in[k]);
      end
    end
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    bx_d       = bx_q;
    c0_d       = c0_q;
    gp_d       = gp_q;
    gg_d       = gg_q;
    if (s2_take) s1_valid_d = 1'b0;
    if (in_accept) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      bx_d       = bx_in;
      c0_d       = sub ? ~cin : cin;
      gp_d       = gp_in;
      gg_d       = gg_in;
    end
  end

  // Every carry is a flat sum of products of registered group or bit PG terms.
  always_comb begin
    logic c_t, prod_t;
    int   base;
    c_t    = 1'b0;
    prod_t = 1'b0;
    base   = 0;
    p_s2   = a_q ^ bx_q;
    g_s2   = a_q & bx_q;
    gc     = '0;
    sum_n  = '0;
    for (int k = 0; k <= NG; k++) begin
      c_t = c0_q;
      for (int j = 0; j < NG; j++) if (j < k) c_t = c_t & gp_q[j];
      for (int j = 0; j < NG; j++) begin
        if (j < k) begin
          prod_t = gg_q[j];
          for (int l = 0; l < NG; l++) if (l > j && l < k) prod_t = prod_t & gp_q[l];
          c_t = c_t | prod_t;
        end
      end
      gc[k] = c_t;
    end
    for (int i = 0; i < WIDTH; i++) begin
      base = (i / GROUP) * GROUP;
      c_t  = gc[i/GROUP];
      for (int j = 0; j < GROUP; j++) if (base + j < i) c_t = c_t & p_s2[base+j];
      for (int j = 0; j < GROUP; j++) begin
        if (base + j < i) begin
          prod_t = g_s2[base+j];
          for (int l = 0; l < GROUP; l++) if (l > j && base + l < i) prod_t = prod_t & p_s2[base+l];
          c_t = c_t | prod_t;
        end
      end
      sum_n[i] = p_s2[i] ^ c_t;
    end

    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
`ifdef CLA_FLAGS_EN
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
`endif
    if (s2_load) out_valid_d = s1_valid_q;
    if (s2_take) begin
      sum_d  = sum_n;
      cout_d = gc[NG];
`ifdef CLA_FLAGS_EN
      ovf_d  = (a_q[WIDTH-1] == bx_q[WIDTH-1]) & (sum_n[WIDTH-1] != a_q[WIDTH-1]);
      zero_d = (sum_n == '0);
      neg_d  = sum_n[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      bx_q        <= '0;
      c0_q        <= 1'b0;
      gp_q        <= '0;
      gg_q        <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef CLA_FLAGS_EN
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      bx_q        <= bx_d;
      c0_q        <= c0_d;
      gp_q        <= gp_d;
      gg_q        <= gg_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
`ifdef CLA_FLAGS_EN
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CLA_FLAGS_EN
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe at WIDTH=16, GROUP=4: directed vectors plus an arithmetic reference model.
// Flag ports are checked when CLA_FLAGS_EN is defined.
module tb_cla_adder_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef CLA_FLAGS_EN
  logic         ovf, zero, neg;
`endif

  int           errors = 0;
  int           checks = 0;
  int           consumed = 0;
  bit           rand_done = 1'b0;
  logic [W+3:0] exp_q[$];

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CLA_FLAGS_EN
    , .ovf(ovf), .zero(zero), .neg(neg)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result as {ovf, zero, neg, cout, sum} from plain integer arithmetic.
  function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    longint ux, uy, ur, sx, sy, sr;
    logic [W-1:0] r;
    logic co, ov;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      ur = ux + uy + longint'(c);
      sr = sx + sy + longint'(c);
      co = (ur >= (longint'(1) << W));
    end else begin
      ur = ux - uy - longint'(c);
      sr = sx - sy - longint'(c);
      co = (ur >= 0);
    end
    r  = ur[W-1:0];
    ov = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
    return {ov, (r == '0), r[W-1], co, r};
  endfunction

  logic         hold_prev = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_cout;

  always @(negedge clk) begin
    logic [W+3:0] e;
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", sum, hold_sum);
        chk("hold_cout", cout, hold_cout);
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sum", sum, e[W-1:0]);
          chk("cout", cout, e[W]);
`ifdef CLA_FLAGS_EN
          chk("neg", neg, e[W+1]);
          chk("zero", zero, e[W+2]);
          chk("ovf", ovf, e[W+3]);
`endif
        end
        consumed++;
      end
      hold_prev = out_valid && !out_ready;
      hold_sum  = sum;
      hold_cout = cout;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    int w = 0;
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [W-1:0] b2b_exp[4];
    int n0, w;
    b2b_exp = '{16'd2, 16'd4, 16'd6, 16'h8000};
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef CLA_FLAGS_EN
    chk("rst_flags", {ovf, zero, neg}, 0);
`endif
    @(posedge clk); #1;

    chk("pin_add_wrap", model(16'hFFFF, 16'h0001, 1'b0, 1'b0), 20'h50000);
    chk("pin_sub_ovf", model(16'h8000, 16'h0001, 1'b0, 1'b1), 20'h97FFF);
    chk("pin_add_ovf", model(16'h7FFF, 16'h0001, 1'b0, 1'b0), 20'hA8000);
    chk("pin_sub_borrow", model(16'h0003, 16'h0005, 1'b1, 1'b1), 20'h2FFFD);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_early_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("wrap_sum", sum, 16'h0000);
    chk("wrap_cout", cout, 1);
`ifdef CLA_FLAGS_EN
    chk("wrap_zero", zero, 1);
    chk("wrap_ovf", ovf, 0);
`endif
    @(posedge clk); #1;

    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("sub_valid", out_valid, 1);
    chk("sub_sum", sum, 16'h7FFF);
    chk("sub_cout", cout, 1);
`ifdef CLA_FLAGS_EN
    chk("sub_ovf", ovf, 1);
    chk("sub_neg", neg, 0);
`endif
    @(posedge clk); #1;

    fork
      begin
        send(16'd1, 16'd1, 1'b0, 1'b0);
        send(16'd2, 16'd2, 1'b0, 1'b0);
        send(16'd3, 16'd3, 1'b0, 1'b0);
        send(16'h7FFF, 16'd1, 1'b0, 1'b0);
      end
      begin
        int wt = 0;
        @(negedge clk);
        while (!out_valid && wt < 20) begin
          @(negedge clk);
          wt++;
        end
        for (int k = 0; k < 4; k++) begin
          chk("b2b_valid", out_valid, 1);
          chk("b2b_sum", sum, b2b_exp[k]);
`ifdef CLA_FLAGS_EN
          chk("b2b_ovf", ovf, (k == 3) ? 1 : 0);
`endif
          @(negedge clk);
        end
      end
    join
    @(posedge clk); #1;

    out_ready = 1'b0;
    n0 = consumed;
    fork
      begin
        send(16'd10, 16'd20, 1'b0, 1'b0);
        send(16'h1234, 16'h1111, 1'b1, 1'b0);
        send(16'd5, 16'd3, 1'b0, 1'b1);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_sum", sum, 16'd30);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    w = 0;
    while (consumed < n0 + 3 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("bp_all_out", consumed - n0, 3);
    @(posedge clk); #1;

    send(16'h0101, 16'h0202, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_beat", out_valid, 0);
    end
    @(posedge clk); #1;

    fork
      begin
        for (int n = 0; n < 1500; n++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
